// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types.
//   word_t   : 32-bit machine word
//   opcode_t : primary opcode field (instr[31:26]); only values the pipeline
//              front end cares about are named here
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    HALT = 6'h3F
  } opcode_t;

endpackage

// File: rtl/pipeline_pkg.sv
// Pipeline-stage types shared by the stage registers.
//   fetch_state_t : fetch sequencer state
//   ifid_t        : IF/ID register payload (also the shape reused by ID/EX)
//   PC_STEP       : default byte increment per sequential fetch
package pipeline_pkg;
  import cpu_types_pkg::*;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
    logic  valid;
  } ifid_t;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// I-side cache request/response bundle.
//   ihit  : cache -> fetch, iload valid this cycle
//   iload : cache -> fetch, instruction word at iaddr
//   iREN  : fetch -> cache, read enable
//   iaddr : fetch -> cache, byte address of the fetch
// master = fetch stage, slave = cache.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iREN;
  word_t iaddr;

  modport master (input ihit, input iload, output iREN, output iaddr);
  modport slave  (output ihit, output iload, input iREN, input iaddr);

endinterface

// File: rtl/pipe_reg_ifid.sv
// IF/ID pipeline register.
//   CLK, RST : clock, synchronous active-high reset (clears everything)
//   en       : load d when high (held low by stall)
//   flush    : insert a bubble (instr=0, valid=0); wins over en
//   d, q     : ifid_t payload in/out
// A flush leaves npc untouched; it carries no meaning while valid=0.
module pipe_reg_ifid
  import pipeline_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  en,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= '0;
    end else if (flush) begin
      q.instr <= '0;
      q.valid <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with PC, fetch sequencer and IF/ID register.
//   CLK, RST     : clock, synchronous active-high reset
//   ic           : I-cache bundle (master side): iREN/iaddr out, ihit/iload in
//   stall        : hazard unit, hold PC and IF/ID
//   redirect_en  : taken branch/jump from EX/MEM, squashes the fetch
//   redirect_pc  : branch/jump target (low two bits ignored)
//   ifid_instr   : registered instruction to decode
//   ifid_npc     : registered PC+PC_STEP of ifid_instr
//   ifid_valid   : ifid_instr is a real instruction
//   fetch_halted : HALT has been fetched, fetch frozen until a redirect
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000,
  parameter int    PC_STEP = pipeline_pkg::PC_STEP
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_unit_if.master ic,
  input  logic         stall,
  input  logic         redirect_en,
  input  word_t        redirect_pc,
  output word_t        ifid_instr,
  output word_t        ifid_npc,
  output logic         ifid_valid,
  output logic         fetch_halted
);

  pipeline_pkg::fetch_state_t state;
  word_t                      pc;
  word_t                      pc_seq;
  logic                       take_hit;
  logic                       is_halt;
  logic                       ifid_en;
  logic                       ifid_flush;
  pipeline_pkg::ifid_t        ifid_d;
  pipeline_pkg::ifid_t        ifid_q;

  assign ic.iREN  = (state == pipeline_pkg::FETCH);
  assign ic.iaddr = pc;

  // Modulo-2^32 increment; the top word wraps to zero silently.
  assign pc_seq = pc + 32'(PC_STEP);

  // A hit is only consumed when nothing of higher priority claims the cycle.
  assign take_hit = (state == pipeline_pkg::FETCH) && ic.ihit && !stall && !redirect_en;
  assign is_halt  = (ic.iload[31:26] == HALT);

  // Bubble whenever the register is not held and no hit is being taken:
  // covers redirects, miss cycles and every cycle spent halted.
  assign ifid_en    = ~stall;
  assign ifid_flush = redirect_en | (~stall & ~take_hit);
  assign ifid_d     = '{instr: ic.iload, npc: pc_seq, valid: 1'b1};

  pipe_reg_ifid u_ifid (
    .CLK   (CLK),
    .RST   (RST),
    .en    (ifid_en),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign ifid_instr = ifid_q.instr;
  assign ifid_npc   = ifid_q.npc;
  assign ifid_valid = ifid_q.valid;

  // state  | meaning
  // FETCH  | issuing reads at pc, advancing on each accepted hit
  // HALTED | HALT passed to decode; pc frozen until a redirect
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc           <= PC_INIT;
      state        <= pipeline_pkg::FETCH;
      fetch_halted <= 1'b0;
    end else if (redirect_en) begin
      pc           <= redirect_pc & ~32'h3;
      state        <= pipeline_pkg::FETCH;
      fetch_halted <= 1'b0;
    end else if (take_hit) begin
      if (is_halt) begin
        state        <= pipeline_pkg::HALTED;
        fetch_halted <= 1'b1;
      end else begin
        pc <= pc_seq;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST;
  logic  stall;
  logic  redirect_en;
  word_t redirect_pc;
  word_t ifid_instr;
  word_t ifid_npc;
  logic  ifid_valid;
  logic  fetch_halted;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit_if ic ();

  fetch_unit dut (
    .CLK          (CLK),
    .RST          (RST),
    .ic           (ic),
    .stall        (stall),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .ifid_instr   (ifid_instr),
    .ifid_npc     (ifid_npc),
    .ifid_valid   (ifid_valid),
    .fetch_halted (fetch_halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Non-HALT instruction word tagged with the low half of its address.
  function automatic word_t word_at(input word_t a);
    return {6'h08, 10'h000, a[15:0]};
  endfunction

  task automatic drive(input logic hit, input word_t ld, input logic stl,
                       input logic rdr, input word_t rpc);
    ic.ihit     = hit;
    ic.iload    = ld;
    stall       = stl;
    redirect_en = rdr;
    redirect_pc = rpc;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_iaddr"},  ic.iaddr,             32'h0);
    chk({tag, "_iren"},   {31'b0, ic.iREN},     32'h1);
    chk({tag, "_instr"},  ifid_instr,           32'h0);
    chk({tag, "_npc"},    ifid_npc,             32'h0);
    chk({tag, "_valid"},  {31'b0, ifid_valid},  32'h0);
    chk({tag, "_halted"}, {31'b0, fetch_halted}, 32'h0);
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk_reset_values("rst");

    // 1: back-to-back hits
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("seq_iaddr", ic.iaddr, 32'(4 * i));
      drive(1'b1, word_at(32'(4 * i)), 1'b0, 1'b0, 32'h0);
      tick();
      chk("seq_instr", ifid_instr, word_at(32'(4 * i)));
      chk("seq_npc",   ifid_npc,   32'(4 * i + 4));
      chk("seq_valid", {31'b0, ifid_valid}, 32'h1);
    end
    chk("seq_iaddr_end", ic.iaddr, 32'h10);

    // redirect back to 8 with a hit present: hit discarded
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h8);
    tick();
    chk("rdr8_iaddr", ic.iaddr, 32'h8);
    chk("rdr8_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rdr8_instr", ifid_instr, 32'h0);

    // 2: three miss cycles at pc=8
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
      tick();
      chk("miss_valid", {31'b0, ifid_valid}, 32'h0);
      chk("miss_instr", ifid_instr, 32'h0);
      chk("miss_iaddr", ic.iaddr, 32'h8);
    end
    drive(1'b1, word_at(32'h8), 1'b0, 1'b0, 32'h0);
    tick();
    chk("miss_end_instr", ifid_instr, word_at(32'h8));
    chk("miss_end_npc",   ifid_npc,   32'hC);
    chk("miss_end_iaddr", ic.iaddr,   32'hC);

    // 3: stall two cycles with hit present
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, word_at(32'hC), 1'b1, 1'b0, 32'h0);
      tick();
      chk("stall_iaddr", ic.iaddr, 32'hC);
      chk("stall_instr", ifid_instr, word_at(32'h8));
      chk("stall_npc",   ifid_npc, 32'hC);
      chk("stall_valid", {31'b0, ifid_valid}, 32'h1);
    end
    drive(1'b1, word_at(32'hC), 1'b0, 1'b0, 32'h0);
    tick();
    chk("unstall_instr", ifid_instr, word_at(32'hC));
    chk("unstall_npc",   ifid_npc,   32'h10);
    chk("unstall_iaddr", ic.iaddr,   32'h10);

    // 4: redirect overrides stall; low address bits masked
    drive(1'b1, word_at(32'h10), 1'b1, 1'b1, 32'h40);
    tick();
    chk("rdr_stall_iaddr", ic.iaddr, 32'h40);
    chk("rdr_stall_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rdr_stall_instr", ifid_instr, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h43);
    tick();
    chk("rdr_mask43", ic.iaddr, 32'h40);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h13);
    tick();
    chk("rdr_mask13", ic.iaddr, 32'h10);

    // 5: HALT at pc=10
    drive(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 32'h0);
    tick();
    chk("halt_instr",  ifid_instr, 32'hFC00_0000);
    chk("halt_npc",    ifid_npc,   32'h14);
    chk("halt_valid",  {31'b0, ifid_valid},   32'h1);
    chk("halt_iren",   {31'b0, ic.iREN},      32'h0);
    chk("halt_flag",   {31'b0, fetch_halted}, 32'h1);
    chk("halt_iaddr",  ic.iaddr,   32'h10);
    drive(1'b1, word_at(32'h14), 1'b1, 1'b0, 32'h0);
    tick();
    chk("halt_stall_instr", ifid_instr, 32'hFC00_0000);
    chk("halt_stall_valid", {31'b0, ifid_valid}, 32'h1);
    drive(1'b1, word_at(32'h14), 1'b0, 1'b0, 32'h0);
    tick();
    chk("halt_bub_instr", ifid_instr, 32'h0);
    chk("halt_bub_valid", {31'b0, ifid_valid},   32'h0);
    chk("halt_bub_iaddr", ic.iaddr, 32'h10);
    chk("halt_bub_flag",  {31'b0, fetch_halted}, 32'h1);
    tick();
    chk("halt_bub2_valid", {31'b0, ifid_valid}, 32'h0);
    chk("halt_bub2_iaddr", ic.iaddr, 32'h10);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
    tick();
    chk("unhalt_iren",  {31'b0, ic.iREN},      32'h1);
    chk("unhalt_iaddr", ic.iaddr,              32'h80);
    chk("unhalt_flag",  {31'b0, fetch_halted}, 32'h0);
    chk("unhalt_valid", {31'b0, ifid_valid},   32'h0);

    // 6: PC wrap, then reset in the middle of a miss
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pre_iaddr", ic.iaddr, 32'hFFFF_FFFC);
    drive(1'b1, word_at(32'hFFFF_FFFC), 1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap_npc",   ifid_npc,   32'h0);
    chk("wrap_iaddr", ic.iaddr,   32'h0);
    chk("wrap_instr", ifid_instr, 32'h2000_FFFC);
    drive(1'b1, word_at(32'h0), 1'b0, 1'b0, 32'h0);
    tick();
    chk("post_wrap_iaddr", ic.iaddr, 32'h4);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("pre_rst_valid", {31'b0, ifid_valid}, 32'h0);
    RST = 1'b1;
    tick();
    chk_reset_values("rst_miss");
    RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
